// File: rtl/chu_pkg.sv
// Shared definitions for the chu iterative divider: state encoding, iteration
// count, divide-by-zero quotient and a two's-complement negation helper.
package chu_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_CYCLES = DIV_WIDTH;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = {DIV_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic [DIV_WIDTH-1:0] twos_neg(input logic [DIV_WIDTH-1:0] x);
    return ~x + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/chu_if.sv
// Start/busy/done handshake bundle between the multiply/divide control and chu.
interface chu_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, q, r
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, q, r
  );

endinterface

// File: rtl/chu_step.sv
// One restoring division iteration on unsigned magnitudes, MSB first.
module chu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // While rem < divisor the trial result lies in (-2^WIDTH, 2^WIDTH), so
  // WIDTH+1 bits hold it and the top bit is the sign. With a zero divisor the
  // remainder only ever holds a prefix of the dividend, so the sign stays clear.
  assign shifted_s = {rem_i, dvd_i[WIDTH-1]};
  assign diff_s    = shifted_s - {1'b0, dvs_i};
  assign qbit_o    = ~diff_s[WIDTH];
  assign rem_o     = qbit_o ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
  assign dvd_o     = {dvd_i[WIDTH-2:0], qbit_o};

endmodule

// File: rtl/chu.sv
// Multi-cycle restoring divider (quotient -> LO, remainder -> HI) with a
// fixed WIDTH+1 cycle latency, signed or unsigned.
module chu
  import chu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic  clk,
  input logic  reset,
  chu_if.slave bus
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rmdr_q;
  logic             busy_q;
  logic             done_q;

  logic             sign_a_d;
  logic             sign_b_d;
  logic [WIDTH-1:0] mag_a_d;
  logic [WIDTH-1:0] mag_b_d;
  logic [WIDTH-1:0] rem_step_d;
  logic [WIDTH-1:0] dvd_step_d;
  logic             qbit_d;
  logic [WIDTH-1:0] quot_fix_d;
  logic [WIDTH-1:0] rmdr_fix_d;

  // Operand signs and magnitudes at capture; |most-negative| fits unsigned.
  always_comb begin
    sign_a_d = bus.is_signed & bus.a[WIDTH-1];
    sign_b_d = bus.is_signed & bus.b[WIDTH-1];
    if (sign_a_d) begin
      mag_a_d = twos_neg(bus.a);
    end else begin
      mag_a_d = bus.a;
    end
    if (sign_b_d) begin
      mag_b_d = twos_neg(bus.b);
    end else begin
      mag_b_d = bus.b;
    end
  end

  chu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i  (rem_q),
    .dvd_i  (dvd_q),
    .dvs_i  (dvs_q),
    .rem_o  (rem_step_d),
    .dvd_o  (dvd_step_d),
    .qbit_o (qbit_d)
  );

  // Sign correction of the magnitude result; zero divisor forces all-ones.
  always_comb begin
    if (dvs_q == {WIDTH{1'b0}}) begin
      quot_fix_d = DIV0_QUOT;
    end else if (sign_a_q ^ sign_b_q) begin
      quot_fix_d = twos_neg(dvd_q);
    end else begin
      quot_fix_d = dvd_q;
    end
    if (sign_a_q) begin
      rmdr_fix_d = twos_neg(rem_q);
    end else begin
      rmdr_fix_d = rem_q;
    end
  end

  // Control FSM with iteration counter, operand registers and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      rem_q    <= {WIDTH{1'b0}};
      dvd_q    <= {WIDTH{1'b0}};
      dvs_q    <= {WIDTH{1'b0}};
      quot_q   <= {WIDTH{1'b0}};
      rmdr_q   <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dvd_q    <= mag_a_d;
            dvs_q    <= mag_b_d;
            rem_q    <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            busy_q   <= 1'b1;
            state_q  <= ST_CALC;
          end
        end
        ST_CALC: begin
          rem_q <= rem_step_d;
          dvd_q <= dvd_step_d;
          cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == LAST_STEP) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          quot_q  <= quot_fix_d;
          rmdr_q  <= rmdr_fix_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.q    = quot_q;
  assign bus.r    = rmdr_q;

endmodule

// File: tb/tb_chu.sv
// Directed self-checking bench for chu: reset state, signed/unsigned results,
// divide-by-zero, overflow, handshake arbitration, mid-operation reset.
module tb_chu;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  chu_if #(.WIDTH(W)) bus ();

  chu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[9];

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled by the following posedge.
  task automatic launch(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic s_v);
    bus.start     = 1'b1;
    bus.a         = a_v;
    bus.b         = b_v;
    bus.is_signed = s_v;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits for done after launch; optionally pulses a stray start at cycle intr_at.
  task automatic collect(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input int intr_at, input bit chk_hold);
    int lat    = 0;
    int busy_n = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_n++;
      if (lat == intr_at) begin
        bus.start     = 1'b1;
        bus.a         = 32'd50;
        bus.b         = 32'd5;
        bus.is_signed = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check_eq({tag, " latency"}, 32'(lat), 32'd33);
    check_eq({tag, " busy cycles"}, 32'(busy_n), 32'd33);
    check_eq({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    check_eq({tag, " q"}, bus.q, eq);
    check_eq({tag, " r"}, bus.r, er);
    if (chk_hold) begin
      @(negedge clk);
      check_eq({tag, " done width"}, 32'(bus.done), 32'd0);
      check_eq({tag, " q hold"}, bus.q, eq);
    end
  endtask

  function automatic void ref_div(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic s_v,
                                  output logic [W-1:0] q_v, output logic [W-1:0] r_v);
    if (b_v == 32'd0) begin
      q_v = 32'hFFFF_FFFF;
      r_v = a_v;
    end else if (s_v && a_v == 32'h8000_0000 && b_v == 32'hFFFF_FFFF) begin
      q_v = 32'h8000_0000;
      r_v = 32'd0;
    end else if (s_v) begin
      q_v = $signed(a_v) / $signed(b_v);
      r_v = $signed(a_v) % $signed(b_v);
    end else begin
      q_v = a_v / b_v;
      r_v = a_v % b_v;
    end
  endfunction

  initial begin
    logic [W-1:0] ra, rb, rq, rr;
    logic         rs;
    int           seen;

    vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
    vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
    vecs[3] = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5};
    vecs[4] = '{32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5};
    vecs[5] = '{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB};
    vecs[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
    vecs[7] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000};
    vecs[8] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("reset busy", 32'(bus.busy), 32'd0);
    check_eq("reset done", 32'(bus.done), 32'd0);
    check_eq("reset q", bus.q, 32'd0);
    check_eq("reset r", bus.r, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].s);
      collect($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, -1, 1'b1);
    end

    // Stray start while busy must not disturb the division in flight.
    launch(32'd1000, 32'd9, 1'b0);
    collect("intrude", 32'd111, 32'd1, 10, 1'b1);
    @(negedge clk);
    check_eq("intrude no restart", 32'(bus.busy), 32'd0);

    // Start in the done cycle is accepted.
    launch(32'd200, 32'd6, 1'b0);
    collect("chain1", 32'd33, 32'd2, -1, 1'b0);
    launch(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);
    collect("chain2", 32'd14, 32'hFFFF_FFFE, -1, 1'b1);

    // Reset mid-operation abandons the division.
    launch(32'd1000, 32'd9, 1'b0);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("midrst busy", 32'(bus.busy), 32'd0);
    check_eq("midrst done", 32'(bus.done), 32'd0);
    check_eq("midrst q", bus.q, 32'd0);
    check_eq("midrst r", bus.r, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check_eq("midrst no done", 32'(seen), 32'd0);
    launch(32'd77, 32'd10, 1'b0);
    collect("after rst", 32'd7, 32'd7, -1, 1'b1);

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      rs = 1'($urandom_range(0, 1));
      ref_div(ra, rb, rs, rq, rr);
      launch(ra, rb, rs);
      collect($sformatf("rnd%0d", i), rq, rr, -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
